lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 54 +++++
 rtl/lsu_align.sv | 47 ++++
 rtl/lsu.sv | 178 +++++++++++++++++
 tb/tb_lsu.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: opcodes, funct3 codes,
// access sizes, FSM state encoding and small decode helpers.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] doubles as the access size code
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Opcodes that produce a register result (rd still has to be non-zero)
  function automatic logic writes_rd(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
                       OPC_AUIPC, OPC_JAL, OPC_JALR};
  endfunction

  // Undefined funct3 codes are reported the same way as misalignment
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic       is_store,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = |addr_lo;
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling: byte enables, store data replication and
// load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [31:0] lane;
  logic        sext;

  // Addressed byte moved down to bit 0
  assign lane = rdata_i >> {addr_lo_i, 3'b000};
  assign sext = ~funct3_i[2];

  // Size-dependent enables, replication and extension
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = rs2_i;
    load_o  = rdata_i;
    case (funct3_i[1:0])
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{rs2_i[7:0]}};
        load_o  = {{24{lane[7] & sext}}, lane[7:0]};
      end
      SZ_H: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{rs2_i[15:0]}};
        load_o  = {{16{lane[15] & sext}}, lane[15:0]};
      end
      SZ_W: begin
        be_o    = 4'b1111;
        wdata_o = rs2_i;
        load_o  = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: retires ALU results directly, runs one data-bus
// transaction at a time for loads/stores, with a bounded wait.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        timeout_hit;
  logic [2:0]  f3_q;
  logic [1:0]  addr_lo_q;
  logic [4:0]  rd_q;
  logic        is_store_q;
  logic        dmem_req_q, dmem_we_q;
  logic [31:0] dmem_addr_q, dmem_wdata_q;
  logic [3:0]  dmem_be_q;
  logic        wb_valid_q, wb_we_q, misalign_q, bus_err_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic        is_mem, is_store;
  logic [2:0]  al_f3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;

  assign is_store    = (opcode == OPC_STORE);
  assign is_mem      = is_store || (opcode == OPC_LOAD);
  assign cnt_d       = cnt_q + CW'(1);
  assign timeout_hit = (cnt_d == CW'(TIMEOUT_CYCLES));

  // In IDLE the aligner sees the incoming op (request build); otherwise the
  // captured op (load extraction in RESP).
  assign al_f3      = (state_q == ST_IDLE) ? funct3 : f3_q;
  assign al_addr_lo = (state_q == ST_IDLE) ? alu_out[1:0] : addr_lo_q;

  lsu_align u_align (
    .funct3_i  (al_f3),
    .addr_lo_i (al_addr_lo),
    .rs2_i     (rs2_data),
    .rdata_i   (dmem_rdata),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .load_o    (al_load)
  );

  // Control FSM with all bus and writeback outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      addr_lo_q    <= '0;
      rd_q         <= '0;
      is_store_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            cnt_q      <= '0;
            f3_q       <= funct3;
            addr_lo_q  <= alu_out[1:0];
            rd_q       <= rd;
            is_store_q <= is_store;
            if (!is_mem) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= writes_rd(opcode) && (rd != 5'd0);
              wb_rd_q    <= rd;
              wb_data_q  <= alu_out;
            end else if (is_misaligned(funct3, is_store, alu_out[1:0])) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= 1'b0;
              wb_rd_q    <= rd;
              wb_data_q  <= '0;
              misalign_q <= 1'b1;
            end else begin
              state_q      <= ST_REQ;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= is_store;
              dmem_addr_q  <= {alu_out[31:2], 2'b00};
              dmem_be_q    <= al_be;
              dmem_wdata_q <= al_wdata;
            end
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_d;
          if (timeout_hit) begin
            state_q    <= ST_IDLE;
            dmem_req_q <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= rd_q;
            wb_data_q  <= '0;
            bus_err_q  <= 1'b1;
          end else if (dmem_gnt) begin
            state_q    <= ST_RESP;
            dmem_req_q <= 1'b0;
          end
        end
        ST_RESP: begin
          cnt_q <= cnt_d;
          if (dmem_rvalid) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= 1'b1;
            wb_we_q    <= !is_store_q && (rd_q != 5'd0);
            wb_rd_q    <= rd_q;
            wb_data_q  <= is_store_q ? 32'd0 : al_load;
          end else if (timeout_hit) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= 1'b1;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= rd_q;
            wb_data_q  <= '0;
            bus_err_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o      = (state_q == ST_IDLE);
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_be      = dmem_be_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_we        = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a driver pushes expected writebacks and bus
// requests; independent monitors pop and compare when the DUT presents them.
module tb_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n, valid_i, ready_o;
  logic [31:0] alu_out, rs2_data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_we, misalign_err, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .alu_out(alu_out), .rs2_data(rs2_data), .opcode(opcode), .funct3(funct3), .rd(rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          chk_data;
    logic        merr;
    logic        berr;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          held;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];
  wb_exp_t  mon_e;
  int       held = 0;
  int       n_tests = 0;
  int       n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit writes_rd_m(input logic [6:0] op);
    return op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h37 ||
           op == 7'h17 || op == 7'h6F || op == 7'h67;
  endfunction

  // Access size in bytes, 0 for an undefined funct3
  function automatic int size_m(input bit st, input logic [2:0] f3);
    if (f3 == 3'd0 || (!st && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (!st && f3 == 3'd5)) return 2;
    if (f3 == 3'd2) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] load_m(input logic [2:0] f3, input logic [1:0] lo,
                                         input logic [31:0] rdat);
    logic [31:0] lane, v;
    lane = rdat >> (8 * int'(lo));
    case (size_m(1'b0, f3))
      1: begin
        v = lane & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      2: begin
        v = lane & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rdat;
    endcase
    return v;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (wb_valid) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        mon_e = wb_q.pop_front();
        $display("[TB] wb rd=%0d we=%0b data=%08h merr=%0b berr=%0b cyc=%0d",
                 wb_rd, wb_we, wb_data, misalign_err, bus_err, cyc);
        chk("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("wb_we", 32'(wb_we), 32'(mon_e.we));
        chk("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
        chk("misalign_err", 32'(misalign_err), 32'(mon_e.merr));
        chk("bus_err", 32'(bus_err), 32'(mon_e.berr));
        if (mon_e.chk_data) chk("wb_data", wb_data, mon_e.data);
      end
    end else if (misalign_err || bus_err) begin
      chk("err_without_wb", {30'd0, misalign_err, bus_err}, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (dmem_req) begin
      if (req_q.size() == 0) begin
        chk("req_unexpected", 32'(dmem_req), 32'd0);
      end else begin
        chk("req_addr", dmem_addr, req_q[0].addr);
        chk("req_be", 32'(dmem_be), 32'(req_q[0].be));
        chk("req_we", 32'(dmem_we), 32'(req_q[0].we));
        if (req_q[0].we) chk("req_wdata", dmem_wdata, req_q[0].wdata);
      end
      held++;
    end else if (held > 0) begin
      if (req_q.size() > 0) begin
        chk("req_held", 32'(held), 32'(req_q[0].held));
        void'(req_q.pop_front());
      end
      held = 0;
    end
  end

  // ---------------- driver ----------------
  // Called and returns at a negedge. gd/rvd = idle cycles before gnt/rvalid.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rdx,
                       input logic [31:0] alu, input logic [31:0] rs2,
                       input int gd, input int rvd, input logic [31:0] rdat);
    int n, g, r, sz;
    bit mem, st, mis;
    wb_exp_t e;
    req_exp_t q;
    n = 0;
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) chk("ready_wait", 32'(ready_o), 32'd1);
    st  = (op == 7'h23);
    mem = st || (op == 7'h03);
    sz  = size_m(st, f3);
    mis = mem && (sz == 0 || (int'(alu[1:0]) % sz) != 0);
    g = gd + 1;
    r = rvd + 1;
    valid_i = 1'b1; opcode = op; funct3 = f3; rd = rdx; alu_out = alu; rs2_data = rs2;
    e.rd = rdx; e.merr = 1'b0; e.berr = 1'b0; e.chk_data = 1'b0; e.data = 32'd0; e.we = 1'b0;
    if (!mem) begin
      e.we = writes_rd_m(op) && rdx != 5'd0;
      e.data = alu; e.chk_data = 1'b1; e.cyc = cyc + 1;
    end else if (mis) begin
      e.merr = 1'b1; e.cyc = cyc + 1;
    end else begin
      q.we = st; q.addr = alu & 32'hFFFF_FFFC;
      q.be = 4'(((1 << sz) - 1) << int'(alu[1:0]));
      q.wdata = (sz == 1) ? rs2[7:0] * 32'h0101_0101 :
                (sz == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
      q.held = (g < T) ? g : T;
      req_q.push_back(q);
      if (g >= T || g + r > T) begin
        e.berr = 1'b1; e.cyc = cyc + T + 1;
      end else begin
        e.we = !st && rdx != 5'd0; e.cyc = cyc + g + r + 1;
        e.data = load_m(f3, alu[1:0], rdat); e.chk_data = !st;
      end
    end
    wb_q.push_back(e);
    @(negedge clk);
    valid_i = 1'b0; alu_out = $urandom; rs2_data = $urandom; rd = 5'($urandom);
    funct3 = 3'($urandom);
    if (mem && !mis) begin
      chk("ready_busy", 32'(ready_o), 32'd0);
      for (int k = 1; k <= g; k++) begin
        dmem_gnt = (k == g);
        dmem_rvalid = (k < g) && ($urandom_range(0, 2) == 0);
        dmem_rdata = $urandom;
        @(negedge clk);
      end
      dmem_gnt = 1'b0;
      for (int j = 1; j <= r; j++) begin
        dmem_rvalid = (j == r);
        dmem_rdata = (j == r) ? rdat : $urandom;
        @(negedge clk);
      end
      dmem_rvalid = $urandom_range(0, 1) == 1;
      dmem_rdata = $urandom;
      @(negedge clk);
      dmem_rvalid = 1'b0;
    end
  endtask

  logic [6:0] ops[10] = '{7'h03, 7'h03, 7'h03, 7'h23, 7'h23, 7'h23,
                          7'h13, 7'h33, 7'h63, 7'h37};

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; alu_out = '0; rs2_data = '0; opcode = '0;
    funct3 = '0; rd = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases
    issue(7'h13, 3'd0, 5'd3, 32'h0000_0005, 32'd0, 0, 0, 32'd0);        // addi
    issue(7'h03, 3'd0, 5'd5, 32'h0000_1003, 32'd0, 0, 0, 32'h80AA_BBCC); // lb
    issue(7'h03, 3'd4, 5'd6, 32'h0000_1003, 32'd0, 0, 0, 32'h80AA_BBCC); // lbu
    issue(7'h23, 3'd1, 5'd0, 32'h0000_2002, 32'h1234_ABCD, 2, 0, 32'd0); // sh, rvalid on last cycle
    issue(7'h03, 3'd2, 5'd8, 32'h0000_3001, 32'd0, 0, 0, 32'd0);         // lw misaligned
    issue(7'h03, 3'd2, 5'd9, 32'h0000_3000, 32'd0, 0, 5, 32'h1111_2222); // timeout in RESP
    issue(7'h23, 3'd2, 5'd1, 32'h0000_3004, 32'hDEAD_BEEF, 3, 0, 32'd0); // timeout in REQ
    issue(7'h63, 3'd0, 5'd9, 32'h0000_0044, 32'd0, 0, 0, 32'd0);         // branch
    issue(7'h13, 3'd0, 5'd0, 32'h0000_0077, 32'd0, 0, 0, 32'd0);         // rd=0
    issue(7'h03, 3'd3, 5'd4, 32'h0000_0010, 32'd0, 0, 0, 32'd0);         // undefined funct3
    issue(7'h03, 3'd5, 5'd7, 32'h0000_0102, 32'd0, 1, 1, 32'h8001_7FFF); // lhu upper lane

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [6:0] op;
      logic [2:0] f3;
      op = ops[$urandom_range(0, 9)];
      f3 = (op == 7'h03 || op == 7'h23) ? 3'($urandom_range(0, 7)) : 3'($urandom);
      issue(op, f3, 5'($urandom), $urandom, $urandom,
            $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
    end

    // reset while waiting in RESP: op must vanish without writeback
    while (!ready_o) @(negedge clk);
    begin
      req_exp_t q;
      q.we = 1'b0; q.addr = 32'h0000_0040; q.be = 4'hF; q.wdata = 32'd0; q.held = 1;
      req_q.push_back(q);
    end
    valid_i = 1'b1; opcode = 7'h03; funct3 = 3'd2; rd = 5'd7; alu_out = 32'h0000_0040;
    @(negedge clk);
    valid_i = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("abort_req", 32'(dmem_req), 32'd0);
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_wb_valid", 32'(wb_valid), 32'd0);
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 60 && (wb_q.size() != 0 || req_q.size() != 0); i++) @(negedge clk);
    chk("drain_wb", 32'(wb_q.size()), 32'd0);
    chk("drain_req", 32'(req_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
